// File: rtl/alu_job_sequencer.sv
// alu_job_sequencer
// AXI4 burst master that shares the memory-mapped ALU/memory slave between
// two requesters. Each accepted job is sent as one 4-beat INCR write burst
// (op1, op2, opcode, 8'h00). A single-beat read of byte 3 then returns the
// result that the slave computed. Requesters are served round-robin, and each
// owns a ring of SLOTS result slots with a stride of 4 bytes.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready [1:0]     job handshake, one bit per requester
//   req_op1/op2/opcode            operands, requester n on [n*DW +: DW]
//   rsp_valid/rsp_ready [1:0]     result handshake, one bit per requester
//   rsp_result, rsp_err           result byte, error flag (resp or timeout)
//   m_aw*/m_w*/m_b*/m_ar*/m_r*    AXI4 master channels
//
// Optional feature: define ALU_JOB_SEQ_TIMEOUT_EN to bound the B and R waits
// by TIMEOUT_CYCLES. Without it, both waits are unbounded.
//
// state  | meaning
// IDLE   | arbitrate, accept a job
// AW     | write address issued
// W      | four write beats
// B      | waiting for write response
// AR     | read address (slot + 3) issued
// R      | waiting for result byte
// RSP    | result presented to the owning requester
module alu_job_sequencer #(
    parameter int                      ADDR_WIDTH     = 32,
    parameter int                      DATA_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0]   REQ0_BASE      = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [ADDR_WIDTH-1:0]   REQ1_BASE      = ADDR_WIDTH'(32'h0000_0100),
    parameter int                      SLOTS          = 16,
    parameter int                      TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [2*DATA_WIDTH-1:0]   req_op1,
    input  logic [2*DATA_WIDTH-1:0]   req_op2,
    input  logic [2*DATA_WIDTH-1:0]   req_opcode,
    output logic [1:0]                rsp_valid,
    input  logic [1:0]                rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_result,
    output logic                      rsp_err,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [3:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic                      m_wvalid,
    output logic                      m_wlast,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic [3:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    input  logic                      m_rlast,
    output logic                      m_rready
);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RSP} state_t;

    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    state_t                  state_q, state_d;
    logic                    id_q, id_d;
    logic                    last_q, last_d;
    logic [DATA_WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d, opc_q, opc_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, araddr_q, araddr_d;
    logic [1:0]              beat_q, beat_d;
    logic [SLOT_W-1:0]       slot_q [2];
    logic [SLOT_W-1:0]       slot_d [2];
`ifdef ALU_JOB_SEQ_TIMEOUT_EN
    localparam logic [15:0]  TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]             tmo_q, tmo_d;
`endif

    logic                    grant_id;
    logic [ADDR_WIDTH-1:0]   acc_addr;

    // On a tie, the requester that was not served last wins.
    always_comb begin
        if (req_valid == 2'b11) grant_id = ~last_q;
        else                    grant_id = req_valid[1];
    end

    assign req_ready = (state_q == S_IDLE && |req_valid) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign acc_addr  = (grant_id ? REQ1_BASE : REQ0_BASE)
                     + (ADDR_WIDTH'(slot_q[grant_id]) << 2);

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        last_d   = last_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        opc_d    = opc_q;
        result_d = result_q;
        err_d    = err_q;
        addr_d   = addr_q;
        araddr_d = araddr_q;
        beat_d   = beat_q;
        slot_d   = slot_q;
`ifdef ALU_JOB_SEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    id_d     = grant_id;
                    op1_d    = grant_id ? req_op1[2*DATA_WIDTH-1:DATA_WIDTH]    : req_op1[DATA_WIDTH-1:0];
                    op2_d    = grant_id ? req_op2[2*DATA_WIDTH-1:DATA_WIDTH]    : req_op2[DATA_WIDTH-1:0];
                    opc_d    = grant_id ? req_opcode[2*DATA_WIDTH-1:DATA_WIDTH] : req_opcode[DATA_WIDTH-1:0];
                    addr_d   = acc_addr;
                    araddr_d = acc_addr + ADDR_WIDTH'(3);
                    state_d  = S_AW;
                end
            end
            S_AW: begin
                if (m_awready) begin
                    beat_d  = 2'd0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (m_wready) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = S_B;
`ifdef ALU_JOB_SEQ_TIMEOUT_EN
                        tmo_d   = 16'd0;
`endif
                    end
                end
            end
            S_B: begin
                if (m_bvalid) begin
                    err_d   = |m_bresp;
                    state_d = S_AR;
                end
`ifdef ALU_JOB_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_RSP;
                end
                else tmo_d = tmo_q + 16'd1;
`endif
            end
            S_AR: begin
                if (m_arready) begin
                    state_d = S_R;
`ifdef ALU_JOB_SEQ_TIMEOUT_EN
                    tmo_d   = 16'd0;
`endif
                end
            end
            S_R: begin
                // A single-beat read that arrives without RLAST is treated as a protocol error.
                if (m_rvalid) begin
                    result_d = m_rdata;
                    err_d    = err_q | (|m_rresp) | ~m_rlast;
                    state_d  = S_RSP;
                end
`ifdef ALU_JOB_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_RSP;
                end
                else tmo_d = tmo_q + 16'd1;
`endif
            end
            S_RSP: begin
                // The slot advances even when the job failed.
                if (rsp_ready[id_q]) begin
                    if (slot_q[id_q] == SLOT_W'(SLOTS - 1)) slot_d[id_q] = '0;
                    else                                    slot_d[id_q] = slot_q[id_q] + SLOT_W'(1);
                    last_d  = id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            op1_q     <= '0;
            op2_q     <= '0;
            opc_q     <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            araddr_q  <= '0;
            beat_q    <= 2'd0;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
`ifdef ALU_JOB_SEQ_TIMEOUT_EN
            tmo_q     <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            last_q    <= last_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            opc_q     <= opc_d;
            result_q  <= result_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            araddr_q  <= araddr_d;
            beat_q    <= beat_d;
            slot_q    <= slot_d;
`ifdef ALU_JOB_SEQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    always_comb begin
        m_wdata = '0;
        if (state_q == S_W) begin
            case (beat_q)
                2'd0:    m_wdata = op1_q;
                2'd1:    m_wdata = op2_q;
                2'd2:    m_wdata = opc_q;
                default: m_wdata = '0;
            endcase
        end
    end

    assign m_awaddr   = addr_q;
    assign m_awlen    = 4'd3;
    assign m_awsize   = 3'd0;
    assign m_awburst  = 2'b01;
    assign m_awvalid  = (state_q == S_AW);
    assign m_wvalid   = (state_q == S_W);
    assign m_wlast    = (state_q == S_W) && (beat_q == 2'd3);
    assign m_bready   = (state_q == S_B);
    assign m_araddr   = araddr_q;
    assign m_arlen    = 4'd0;
    assign m_arsize   = 3'd0;
    assign m_arburst  = 2'b01;
    assign m_arvalid  = (state_q == S_AR);
    assign m_rready   = (state_q == S_R);
    assign rsp_valid  = (state_q == S_RSP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_job_sequencer.sv
module tb_alu_job_sequencer;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int SLOTS = 2;
    localparam int TMO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req_valid = 2'b00, req_ready;
    logic [2*DW-1:0] req_op1 = '0, req_op2 = '0, req_opcode = '0;
    logic [1:0] rsp_valid, rsp_ready = 2'b00;
    logic [DW-1:0] rsp_result;
    logic rsp_err;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [3:0] m_awlen, m_arlen;
    logic [2:0] m_awsize, m_arsize;
    logic [1:0] m_awburst, m_arburst;
    logic m_awvalid, m_awready = 1'b0;
    logic [DW-1:0] m_wdata;
    logic m_wvalid, m_wlast, m_wready = 1'b0;
    logic [1:0] m_bresp = 2'b00;
    logic m_bvalid = 1'b0, m_bready;
    logic m_arvalid, m_arready = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0] m_rresp = 2'b00;
    logic m_rvalid = 1'b0, m_rlast = 1'b0, m_rready;

    always #5 clk = ~clk;

    alu_job_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REQ0_BASE(32'h0000_0000), .REQ1_BASE(32'h0000_0100),
        .SLOTS(SLOTS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Opcode map of the bench's slave ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor.
    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        case (op)
            8'd0:    return a + b;
            8'd1:    return a - b;
            8'd2:    return a & b;
            8'd3:    return a | b;
            8'd4:    return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- slave model (drives at negedge) ----------------
    int aw_stall = 0, w_stall = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic rlast_cfg = 1'b1;
    bit b_never = 0;
    int aw_wait = 0, w_wait = 0, wbeat = 0, nbeats = 0;
    bit aw_held = 0, w_held = 0, hold_ok = 1, wlast_ok = 1;
    logic [31:0] aw_hold = '0, cap_awaddr = '0, cap_araddr = '0;
    logic [7:0] w_hold_d = '0;
    logic w_hold_l = 1'b0;
    logic [8:0] aw_attr = '0, ar_attr = '0;
    logic [7:0] wbuf [4];
    logic [7:0] mem [0:511];

    initial begin : slave
        logic [8:0] sa;
        forever begin
            @(negedge clk);
            m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
            if (rst) begin
                aw_held = 0; w_held = 0; wbeat = 0; aw_wait = 0; w_wait = 0;
            end else begin
                if (m_awvalid) begin
                    if (!aw_held) begin
                        aw_wait = aw_stall; aw_hold = m_awaddr; aw_held = 1;
                    end else if (m_awaddr !== aw_hold) hold_ok = 0;
                    if (aw_wait > 0) aw_wait--;
                    else begin
                        m_awready = 1'b1; aw_held = 0;
                        cap_awaddr = m_awaddr; aw_attr = {m_awlen, m_awsize, m_awburst};
                        wbeat = 0; w_wait = w_stall; w_held = 0;
                    end
                end
                if (m_wvalid) begin
                    if (w_held && (m_wdata !== w_hold_d || m_wlast !== w_hold_l)) hold_ok = 0;
                    if (wbeat == 2 && w_wait > 0) begin
                        w_wait--; w_held = 1; w_hold_d = m_wdata; w_hold_l = m_wlast;
                    end else begin
                        m_wready = 1'b1; w_held = 0;
                        if (wbeat < 4) wbuf[wbeat] = m_wdata;
                        if (m_wlast !== (wbeat == 3)) wlast_ok = 0;
                        wbeat++;
                    end
                end
                if (m_bready && !b_never) begin
                    m_bvalid = 1'b1; m_bresp = bresp_cfg; nbeats = wbeat;
                    sa = cap_awaddr[8:0];
                    mem[sa] = wbuf[0]; mem[sa + 9'd1] = wbuf[1]; mem[sa + 9'd2] = wbuf[2];
                    mem[sa + 9'd3] = alu(wbuf[0], wbuf[1], wbuf[2]);
                end
                if (m_arvalid) begin
                    m_arready = 1'b1; cap_araddr = m_araddr; ar_attr = {m_arlen, m_arsize, m_arburst};
                end
                if (m_rready) begin
                    m_rvalid = 1'b1; m_rdata = mem[cap_araddr[8:0]]; m_rresp = rresp_cfg; m_rlast = rlast_cfg;
                end
            end
        end
    end

    // ---------------- job driver ----------------
    task automatic check_reset_vals();
        check("rst_ctrl", {req_ready, rsp_valid, m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready}, 0);
        check("rst_result", {rsp_result, rsp_err}, 0);
        check("rst_awaddr", m_awaddr, 0);
        check("rst_araddr", m_araddr, 0);
        check("rst_wdata", m_wdata, 0);
        check("rst_aw_attr", {m_awlen, m_awsize, m_awburst}, {4'd3, 3'd0, 2'b01});
        check("rst_ar_attr", {m_arlen, m_arsize, m_arburst}, {4'd0, 3'd0, 2'b01});
    endtask

    task automatic do_job(input logic [1:0] mask,
                          input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] c0,
                          input logic [7:0] a1, input logic [7:0] b1, input logic [7:0] c1,
                          input logic [1:0] bresp, input logic [1:0] rresp, input logic rlast,
                          input int aws, input int ws, input logic eg, input logic [31:0] ea,
                          input logic [7:0] er, input logic ee, input bit chk_lat);
        int n;
        logic [1:0] oh;
        oh = eg ? 2'b10 : 2'b01;
        @(negedge clk);
        bresp_cfg = bresp; rresp_cfg = rresp; rlast_cfg = rlast; aw_stall = aws; w_stall = ws;
        hold_ok = 1; wlast_ok = 1; nbeats = 0; cap_awaddr = '1; cap_araddr = '1;
        for (int k = 0; k < 4; k++) wbuf[k] = 8'hEE;
        req_op1 = {a1, a0}; req_op2 = {b1, b0}; req_opcode = {c1, c0}; req_valid = mask;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 50) begin @(negedge clk); #1; n++; end
        check("grant", req_ready, oh);
        @(negedge clk);
        req_valid = 2'b00;
        n = 1;
        while (rsp_valid == 2'b00 && n < 300) begin @(negedge clk); n++; end
        if (chk_lat) check("rsp_cycle", n, 9);
        check("rsp_valid", rsp_valid, oh);
        check("rsp_result", rsp_result, er);
        check("rsp_err", rsp_err, ee);
        check("awaddr", cap_awaddr, ea);
        check("araddr", cap_araddr, ea + 32'd3);
        check("aw_attr", aw_attr, {4'd3, 3'd0, 2'b01});
        check("ar_attr", ar_attr, {4'd0, 3'd0, 2'b01});
        check("wbeats", {wbuf[0], wbuf[1], wbuf[2], wbuf[3]},
              eg ? {a1, b1, c1, 8'h00} : {a0, b0, c0, 8'h00});
        check("beat_count", nbeats, 4);
        check("wlast_pos", wlast_ok, 1);
        check("payload_hold", hold_ok, 1);
        @(negedge clk);
        check("rsp_held", {rsp_valid, rsp_result, rsp_err}, {oh, er, ee});
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = 2'b00;
        check("idle_after_rsp", rsp_valid, 2'b00);
    endtask

    typedef struct {
        logic [1:0] mask;
        logic [7:0] op1, op2, opc;
        logic [1:0] bresp, rresp;
        logic       rlast;
        int         aws, ws;
        logic       eg;
        logic [31:0] ea;
        logic [7:0] er;
        logic       ee;
    } vec_t;

    vec_t tbl [10];

    initial begin : main
        logic last_m;
        int done_m [2];
        int n, bcnt;
        bit seen;
        logic [1:0] mask, br, rr;
        logic [7:0] a0, b0, c0, a1, b1, c1, er;
        logic g, rl;
        logic [31:0] ea;

        //         mask   op1    op2    opc  bresp  rresp rlast aws ws eg  ea            er     ee
        tbl[0] = '{2'b11, 8'h05, 8'h03, 8'd0, 2'b00, 2'b00, 1'b1, 0, 0, 1'b0, 32'h000, 8'h08, 1'b0};
        tbl[1] = '{2'b11, 8'h10, 8'h20, 8'd0, 2'b00, 2'b00, 1'b1, 0, 0, 1'b1, 32'h100, 8'h30, 1'b0};
        tbl[2] = '{2'b11, 8'h0F, 8'hF0, 8'd3, 2'b00, 2'b00, 1'b1, 0, 0, 1'b0, 32'h004, 8'hFF, 1'b0};
        tbl[3] = '{2'b11, 8'h33, 8'h11, 8'd1, 2'b00, 2'b00, 1'b1, 0, 0, 1'b1, 32'h104, 8'h22, 1'b0};
        tbl[4] = '{2'b01, 8'hAA, 8'h0F, 8'd2, 2'b00, 2'b00, 1'b1, 0, 0, 1'b0, 32'h000, 8'h0A, 1'b0};
        tbl[5] = '{2'b01, 8'h01, 8'h02, 8'd0, 2'b10, 2'b00, 1'b1, 0, 0, 1'b0, 32'h004, 8'h03, 1'b1};
        tbl[6] = '{2'b10, 8'hFF, 8'h01, 8'd0, 2'b00, 2'b10, 1'b1, 0, 0, 1'b1, 32'h100, 8'h00, 1'b1};
        tbl[7] = '{2'b01, 8'h12, 8'h34, 8'd4, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0, 32'h000, 8'h26, 1'b1};
        tbl[8] = '{2'b01, 8'h08, 8'h07, 8'd1, 2'b00, 2'b00, 1'b1, 3, 2, 1'b0, 32'h004, 8'h01, 1'b0};
        tbl[9] = '{2'b10, 8'h5A, 8'hA5, 8'd4, 2'b00, 2'b00, 1'b1, 0, 0, 1'b1, 32'h104, 8'hFF, 1'b0};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        // Table: the granted lane carries the vector, the other lane carries decoys.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].eg)
                do_job(tbl[i].mask, ~tbl[i].op1, ~tbl[i].op2, 8'h07, tbl[i].op1, tbl[i].op2, tbl[i].opc,
                       tbl[i].bresp, tbl[i].rresp, tbl[i].rlast, tbl[i].aws, tbl[i].ws,
                       tbl[i].eg, tbl[i].ea, tbl[i].er, tbl[i].ee, (tbl[i].aws == 0 && tbl[i].ws == 0));
            else
                do_job(tbl[i].mask, tbl[i].op1, tbl[i].op2, tbl[i].opc, ~tbl[i].op1, ~tbl[i].op2, 8'h07,
                       tbl[i].bresp, tbl[i].rresp, tbl[i].rlast, tbl[i].aws, tbl[i].ws,
                       tbl[i].eg, tbl[i].ea, tbl[i].er, tbl[i].ee, (tbl[i].aws == 0 && tbl[i].ws == 0));
        end

        // Reset in the middle of the write burst drops the job.
        @(negedge clk);
        req_op1 = 16'h0102; req_op2 = 16'h0304; req_opcode = 16'h0000; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        n = 0;
        while (!m_wvalid && n < 20) begin @(negedge clk); n++; end
        check("reached_w", m_wvalid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || m_awvalid || m_wvalid) seen = 1;
        end
        check("no_job_after_rst", seen, 0);

        // Random jobs against a job-level model: ring position = jobs served modulo SLOTS.
        last_m = 1'b1;
        done_m[0] = 0; done_m[1] = 0;
        for (int j = 0; j < 30; j++) begin
            mask = 2'($urandom_range(1, 3));
            a0 = 8'($urandom); b0 = 8'($urandom); c0 = 8'($urandom_range(0, 4));
            a1 = 8'($urandom); b1 = 8'($urandom); c1 = 8'($urandom_range(0, 4));
            br = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            rr = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
            rl = ($urandom_range(0, 7) != 0);
            g  = (mask == 2'b11) ? ~last_m : mask[1];
            ea = (g ? 32'h100 : 32'h000) + 32'((done_m[g] % SLOTS) * 4);
            er = g ? alu(a1, b1, c1) : alu(a0, b0, c0);
            n  = $urandom_range(0, 2);
            bcnt = $urandom_range(0, 2);
            do_job(mask, a0, b0, c0, a1, b1, c1, br, rr, rl, n, bcnt, g, ea, er,
                   (br != 2'b00) || (rr != 2'b00) || !rl, (n == 0 && bcnt == 0));
            done_m[g]++;
            last_m = g;
        end

`ifdef ALU_JOB_SEQ_TIMEOUT_EN
        // Slave never answers the write: job ends with an error after TMO cycles in B.
        b_never = 1;
        @(negedge clk);
        req_op1 = 16'h0011; req_op2 = 16'h0022; req_opcode = 16'h0000; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        n = 0; bcnt = 0;
        while (rsp_valid == 2'b00 && n < 300) begin
            if (m_bready) bcnt++;
            @(negedge clk);
            n++;
        end
        check("tmo_b_cycles", bcnt, TMO);
        check("tmo_rsp_valid", rsp_valid, 2'b01);
        check("tmo_err", rsp_err, 1'b1);
        check("tmo_result", rsp_result, 8'h00);
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        b_never = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
